// File: rtl/priority_decoder_2x4_dispatch.sv
// priority_decoder_2x4_dispatch: turns encoded winners into held, acknowledged one-hot lines with timeout.
// Optional one-entry skid buffer enabled by defining PRIORITY_DECODER_SKID_EN.
module priority_decoder_2x4_dispatch #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
  input  logic       in_none,
  output logic [3:0] line,
  input  logic [3:0] ack,
  output logic       busy,
  output logic       none_seen,
  output logic       timeout,
  output logic       err
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic {IDLE, ASSERT} state_t;
  state_t state, state_n;
  logic [3:0] line_n;
  logic [CW-1:0] cnt, cnt_n;
  logic fire, hit, expire, go, go_none;
  logic [2:0] go_code;
  assign fire = in_valid && in_ready;
  assign hit = state == ASSERT && |(ack & line);
  assign expire = state == ASSERT && !hit && TIMEOUT > 0 && cnt == CW'(TIMEOUT - 1);
  assign busy = state == ASSERT;
`ifdef PRIORITY_DECODER_SKID_EN
  logic skid_full, skid_none;
  logic [2:0] skid_code;
  assign in_ready = !skid_full;
  // a release with an empty skid may take a same-edge transfer straight through
  assign go = (state == IDLE && fire) || ((hit || expire) && (skid_full || fire));
  assign go_none = skid_full ? skid_none : in_none;
  assign go_code = skid_full ? skid_code : in_code;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      skid_full <= 1'b0;
      skid_none <= 1'b0;
      skid_code <= '0;
    end else if (hit || expire) begin
      skid_full <= 1'b0;
    end else if (state == ASSERT && fire) begin
      skid_full <= 1'b1;
      skid_none <= in_none;
      skid_code <= in_code;
    end
`else
  assign in_ready = state == IDLE;
  assign go = fire;
  assign go_none = in_none;
  assign go_code = in_code;
`endif
  always_comb begin
    state_n = state;
    line_n = line;
    cnt_n = cnt;
    if (state == ASSERT) begin
      if (hit || expire) begin
        state_n = IDLE;
        line_n = '0;
      end else if (cnt != '1) cnt_n = cnt + 1'b1;
    end
    if (go && !go_none && !go_code[2]) begin
      state_n = ASSERT;
      line_n = 4'b0001 << go_code[1:0];
      cnt_n = '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      line <= '0;
      cnt <= '0;
      none_seen <= 1'b0;
      timeout <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      line <= line_n;
      cnt <= cnt_n;
      none_seen <= go && go_none;
      timeout <= expire;
      if (go && !go_none && go_code[2]) err <= 1'b1;
    end
endmodule
